// File: rtl/mux_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_pkg
// Description : Shared types, constants and the next-channel search function
//               for the mux scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_scan_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] chan;
    } next_t;

    // Lowest set bit of mask strictly above cur; cur = -1 searches from the bottom.
    function automatic next_t next_chan(input logic [NCH-1:0] mask, input int cur);
        next_t res;
        res.found = 1'b0;
        res.chan  = '0;
        // Walk downwards so the last hit is the lowest qualifying channel.
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i] && (i > cur)) begin
                res.found = 1'b1;
                res.chan  = SEL_W'(i);
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_ctrl_if
// Description : Request, mux-facing and result signals of the scan controller.
//               master = requester/mux side, slave = controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_scan_ctrl_if;
    import mux_scan_pkg::*;

    logic                start;
    logic [NCH-1:0]      chan_mask;
    logic                mux_out;
    logic [SEL_W-1:0]    sel;
    logic                busy;
    logic                done;
    logic [NCH-1:0]      sample;
    logic [NCH-1:0]      valid_mask;

    modport master (
        output start, chan_mask, mux_out,
        input  sel, busy, done, sample, valid_mask
    );

    modport slave (
        input  start, chan_mask, mux_out,
        output sel, busy, done, sample, valid_mask
    );

endinterface
`default_nettype wire

// File: rtl/mux_scan_next.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_next
// Description : Combinational finder for the next enabled channel. With
//               first=1 it returns the lowest set bit; otherwise the lowest
//               set bit above cur_sel.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_next
    import mux_scan_pkg::*;
(
    input  wire logic [NCH-1:0]   mask,
    input  wire logic [SEL_W-1:0] cur_sel,
    input  wire logic             first,
    output logic                  found,
    output logic [SEL_W-1:0]      chan
);

    int    w_cur;
    next_t w_res;

    // Search origin: -1 for the first channel, the current select otherwise.
    always_comb begin
        w_cur = first ? -1 : int'(cur_sel);
        w_res = next_chan(mask, w_cur);
        found = w_res.found;
        chan  = w_res.chan;
    end

endmodule
`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_ctrl
// Description : Walks the enabled channels of a 4:1 mux in ascending order,
//               holding each select for DWELL cycles, samples the mux output
//               at the end of each dwell and reports the assembled word with
//               a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_ctrl #(
    parameter int DWELL = 2,   // legal range 1..255
    parameter int NCH   = 4    // fixed at 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mux_scan_ctrl_if.slave   bus
);
    import mux_scan_pkg::*;

    localparam int c_CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DWELL - 1);

    state_t             r_state;
    logic [SEL_W-1:0]   r_sel;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [NCH-1:0]     r_sample;
    logic [NCH-1:0]     r_mask;

    logic [NCH-1:0]     w_find_mask;
    logic               w_find_first;
    logic               w_found;
    logic [SEL_W-1:0]   w_next_sel;

    // In IDLE the finder looks at the live request mask from the bottom;
    // while scanning it looks above the current select in the latched mask.
    always_comb begin
        w_find_first = (r_state == IDLE);
        w_find_mask  = w_find_first ? bus.chan_mask : r_mask;
    end

    mux_scan_next u_next (
        .mask    (w_find_mask),
        .cur_sel (r_sel),
        .first   (w_find_first),
        .found   (w_found),
        .chan    (w_next_sel)
    );

    // Scan sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_sel    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sample <= '0;
            r_mask   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_mask   <= bus.chan_mask;
                        r_sample <= '0;
                        r_cnt    <= '0;
                        if (w_found) begin
                            r_sel   <= w_next_sel;
                            r_busy  <= 1'b1;
                            r_state <= SCAN;
                        end else begin
                            // Empty mask: report an all-zero result immediately.
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                SCAN: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_sample[r_sel] <= bus.mux_out;
                        r_cnt           <= '0;
                        if (w_found) begin
                            r_sel <= w_next_sel;
                        end else begin
                            // sel keeps the last channel scanned.
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.sel        = r_sel;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.sample     = r_sample;
    assign bus.valid_mask = r_mask;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan_ctrl
// Description : Directed bench for mux_scan_ctrl. Two instances (DWELL=2 and
//               DWELL=1), each feeding a behavioural 4:1 mux driven by data_in.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] data_in2;
    logic [3:0] data_in1;

    int vectors;
    int miscompares;

    mux_scan_ctrl_if bus2 ();
    mux_scan_ctrl_if bus1 ();

    // Behavioural 4:1 mux in front of each controller.
    assign bus2.mux_out = data_in2[bus2.sel];
    assign bus1.mux_out = data_in1[bus1.sel];

    mux_scan_ctrl #(.DWELL(2), .NCH(4)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
    mux_scan_ctrl #(.DWELL(1), .NCH(4)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and settle past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        vectors++; if (bus2.sel !== 2'd0)        begin miscompares++; $display("FAIL reset sel2 got %0d exp 0", bus2.sel); end
        vectors++; if (bus2.busy !== 1'b0)       begin miscompares++; $display("FAIL reset busy2 got %b exp 0", bus2.busy); end
        vectors++; if (bus2.done !== 1'b0)       begin miscompares++; $display("FAIL reset done2 got %b exp 0", bus2.done); end
        vectors++; if (bus2.sample !== 4'b0)     begin miscompares++; $display("FAIL reset sample2 got %b exp 0000", bus2.sample); end
        vectors++; if (bus2.valid_mask !== 4'b0) begin miscompares++; $display("FAIL reset valid2 got %b exp 0000", bus2.valid_mask); end
        vectors++; if (bus1.busy !== 1'b0 || bus1.done !== 1'b0 || bus1.sel !== 2'd0)
            begin miscompares++; $display("FAIL reset dut1 got busy=%b done=%b sel=%0d exp 0/0/0", bus1.busy, bus1.done, bus1.sel); end
        rst = 1'b0;
    endtask

    task automatic test_full_scan();
        logic [1:0] exp_sel;
        step();
        data_in2       = 4'b1010;
        bus2.chan_mask = 4'b1111;
        bus2.start     = 1'b1;               // cycle 0
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c == 1) begin
                bus2.start     = 1'b0;
                bus2.chan_mask = 4'b0000;    // must not affect the running scan
            end
            exp_sel = (c <= 8) ? 2'((c - 1) / 2) : 2'd3;
            vectors++; if (bus2.busy !== (c <= 8)) begin miscompares++; $display("FAIL full_scan busy c=%0d got %b exp %b", c, bus2.busy, (c <= 8)); end
            vectors++; if (bus2.done !== (c == 9)) begin miscompares++; $display("FAIL full_scan done c=%0d got %b exp %b", c, bus2.done, (c == 9)); end
            vectors++; if (bus2.sel !== exp_sel)   begin miscompares++; $display("FAIL full_scan sel c=%0d got %0d exp %0d", c, bus2.sel, exp_sel); end
            if (c >= 9) begin
                vectors++; if (bus2.sample !== 4'b1010)     begin miscompares++; $display("FAIL full_scan sample c=%0d got %b exp 1010", c, bus2.sample); end
                vectors++; if (bus2.valid_mask !== 4'b1111) begin miscompares++; $display("FAIL full_scan valid c=%0d got %b exp 1111", c, bus2.valid_mask); end
            end
        end
    endtask

    task automatic test_sparse_mask();
        logic [1:0] exp_sel;
        step();
        data_in2       = 4'b1111;
        bus2.chan_mask = 4'b0101;
        bus2.start     = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            bus2.start = 1'b0;
            exp_sel = (c <= 2) ? 2'd0 : 2'd2;
            vectors++; if (bus2.busy !== (c <= 4)) begin miscompares++; $display("FAIL sparse busy c=%0d got %b exp %b", c, bus2.busy, (c <= 4)); end
            vectors++; if (bus2.done !== (c == 5)) begin miscompares++; $display("FAIL sparse done c=%0d got %b exp %b", c, bus2.done, (c == 5)); end
            vectors++; if (bus2.sel !== exp_sel)   begin miscompares++; $display("FAIL sparse sel c=%0d got %0d exp %0d", c, bus2.sel, exp_sel); end
        end
        vectors++; if (bus2.sample !== 4'b0101)     begin miscompares++; $display("FAIL sparse sample got %b exp 0101", bus2.sample); end
        vectors++; if (bus2.valid_mask !== 4'b0101) begin miscompares++; $display("FAIL sparse valid got %b exp 0101", bus2.valid_mask); end
    endtask

    task automatic test_empty_mask();
        step();
        data_in2       = 4'b1111;
        bus2.chan_mask = 4'b0000;
        bus2.start     = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            bus2.start = 1'b0;
            vectors++; if (bus2.busy !== 1'b0)     begin miscompares++; $display("FAIL empty busy c=%0d got %b exp 0", c, bus2.busy); end
            vectors++; if (bus2.done !== (c == 1)) begin miscompares++; $display("FAIL empty done c=%0d got %b exp %b", c, bus2.done, (c == 1)); end
        end
        vectors++; if (bus2.sample !== 4'b0000)     begin miscompares++; $display("FAIL empty sample got %b exp 0000", bus2.sample); end
        vectors++; if (bus2.valid_mask !== 4'b0000) begin miscompares++; $display("FAIL empty valid got %b exp 0000", bus2.valid_mask); end
    endtask

    task automatic test_back_to_back();
        logic       exp_busy;
        logic       exp_done;
        logic [3:0] exp_sample;
        step();
        data_in2       = 4'b0001;
        bus2.chan_mask = 4'b0001;
        bus2.start     = 1'b1;               // held high: scans at cycles 0, 4, 8
        for (int c = 1; c <= 13; c++) begin
            step();
            exp_busy = (c <= 11) && ((c % 4 == 1) || (c % 4 == 2));
            exp_done = (c <= 11) && (c % 4 == 3);
            vectors++; if (bus2.busy !== exp_busy) begin miscompares++; $display("FAIL b2b busy c=%0d got %b exp %b", c, bus2.busy, exp_busy); end
            vectors++; if (bus2.done !== exp_done) begin miscompares++; $display("FAIL b2b done c=%0d got %b exp %b", c, bus2.done, exp_done); end
            if (exp_done) begin
                exp_sample = (c == 7) ? 4'b0000 : 4'b0001;
                vectors++; if (bus2.sample !== exp_sample) begin miscompares++; $display("FAIL b2b sample c=%0d got %b exp %b", c, bus2.sample, exp_sample); end
            end
            if (c == 4)  data_in2 = 4'b0000;
            if (c == 8)  data_in2 = 4'b0001;
            if (c == 11) bus2.start = 1'b0;  // DONE cycle; no scan at cycle 12
        end
    endtask

    task automatic test_reset_mid_scan();
        step();
        data_in2       = 4'b0110;
        bus2.chan_mask = 4'b1111;
        bus2.start     = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            bus2.start = 1'b0;
        end
        rst = 1'b1;                          // cycle 4
        step();
        rst = 1'b0;
        vectors++; if (bus2.sel !== 2'd0)        begin miscompares++; $display("FAIL abort sel got %0d exp 0", bus2.sel); end
        vectors++; if (bus2.busy !== 1'b0)       begin miscompares++; $display("FAIL abort busy got %b exp 0", bus2.busy); end
        vectors++; if (bus2.sample !== 4'b0)     begin miscompares++; $display("FAIL abort sample got %b exp 0000", bus2.sample); end
        vectors++; if (bus2.valid_mask !== 4'b0) begin miscompares++; $display("FAIL abort valid got %b exp 0000", bus2.valid_mask); end
        for (int c = 5; c <= 12; c++) begin
            vectors++; if (bus2.done !== 1'b0 || bus2.busy !== 1'b0)
                begin miscompares++; $display("FAIL abort idle c=%0d got done=%b busy=%b exp 0/0", c, bus2.done, bus2.busy); end
            step();
        end
        bus2.start = 1'b1;                   // new cycle 0
        for (int c = 1; c <= 9; c++) begin
            step();
            bus2.start = 1'b0;
            vectors++; if (bus2.busy !== (c <= 8)) begin miscompares++; $display("FAIL rescan busy c=%0d got %b exp %b", c, bus2.busy, (c <= 8)); end
            vectors++; if (bus2.done !== (c == 9)) begin miscompares++; $display("FAIL rescan done c=%0d got %b exp %b", c, bus2.done, (c == 9)); end
        end
        vectors++; if (bus2.sample !== 4'b0110)     begin miscompares++; $display("FAIL rescan sample got %b exp 0110", bus2.sample); end
        vectors++; if (bus2.valid_mask !== 4'b1111) begin miscompares++; $display("FAIL rescan valid got %b exp 1111", bus2.valid_mask); end
    endtask

    task automatic test_dwell1();
        step();
        data_in1       = 4'b1000;
        bus1.chan_mask = 4'b1000;
        bus1.start     = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            bus1.start = 1'b0;
            vectors++; if (bus1.busy !== (c == 1)) begin miscompares++; $display("FAIL dwell1 busy c=%0d got %b exp %b", c, bus1.busy, (c == 1)); end
            vectors++; if (bus1.done !== (c == 2)) begin miscompares++; $display("FAIL dwell1 done c=%0d got %b exp %b", c, bus1.done, (c == 2)); end
            vectors++; if (bus1.sel !== 2'd3)      begin miscompares++; $display("FAIL dwell1 sel c=%0d got %0d exp 3", c, bus1.sel); end
        end
        vectors++; if (bus1.sample !== 4'b1000)     begin miscompares++; $display("FAIL dwell1 sample got %b exp 1000", bus1.sample); end
        vectors++; if (bus1.valid_mask !== 4'b1000) begin miscompares++; $display("FAIL dwell1 valid got %b exp 1000", bus1.valid_mask); end
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst            = 1'b1;
        data_in2       = 4'b0000;
        data_in1       = 4'b0000;
        bus2.start     = 1'b0;
        bus2.chan_mask = 4'b0000;
        bus1.start     = 1'b0;
        bus1.chan_mask = 4'b0000;

        test_reset();
        test_full_scan();
        test_sparse_mask();
        test_empty_mask();
        test_back_to_back();
        test_reset_mid_scan();
        test_dwell1();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
